// File: rtl/wb_writeback_unit.sv
// Purpose: MEM/WB pipeline register, load/ALU result select, register-file write port driver,
//          and per-register pending-write scoreboard that raises hazard to stall issue.
// Latency: MEM->WB 1 cycle; hazard is combinational from scoreboard state and current retire.
// Backpressure: freeze holds the MEM/WB register and suppresses retire/accept; hazard stalls decode.
// Optional feature: define WB_STATS_EN to add the wb_count retire counter output.
// Ports:
//   clk, rst                    clock (posedge), asynchronous active-high reset
//   freeze                      pipeline stall
//   issue_valid/_wb_en/_dest    decode-stage instruction and its destination
//   id_src1, id_src2, two_src   decode operand indices (src2 only when two_src)
//   mem_valid/_wb_en/_r_en      MEM-stage instruction qualifiers (r_en selects load data)
//   mem_dest, alu_result, mem_data
//   wb_en, wb_dest, wb_value    register file write port
//   hazard                      decode must stall
//   sb_error                    sticky: retire against an empty pending counter
//   wb_count (WB_STATS_EN)      number of retired writes since reset
module wb_writeback_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              issue_valid,
  input  logic              issue_wb_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              two_src,
  input  logic              mem_valid,
  input  logic              mem_wb_en,
  input  logic              mem_r_en,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_value,
  output logic              hazard,
  output logic              sb_error
`ifdef WB_STATS_EN
  ,
  output logic [31:0]       wb_count
`endif
);

  localparam int CNT_W = $clog2(MAX_PEND + 1);

  logic              valid_q;
  logic              wb_en_q;
  logic [ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0] value_q;

  logic [CNT_W-1:0]  cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  logic retire;
  logic accept;
  logic pend1;
  logic pend2;
  logic full;

  // MEM/WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      wb_en_q <= 1'b0;
      dest_q  <= '0;
      value_q <= '0;
    end else if (!freeze) begin
      valid_q <= mem_valid;
      wb_en_q <= mem_wb_en;
      dest_q  <= mem_dest;
      value_q <= mem_r_en ? mem_data : alu_result;
    end
  end

  // Gating with freeze makes a held instruction write once, in its first unfrozen cycle.
  assign wb_en    = valid_q & wb_en_q & ~freeze;
  assign wb_dest  = dest_q;
  assign wb_value = value_q;

  assign retire = wb_en;

  // The register file writes on negedge, so a retiring write is already visible to decode
  // this cycle: discount it when judging pending and full.
  always_comb begin
    pend1 = cnt[id_src1] > CNT_W'(retire && (wb_dest == id_src1));
    pend2 = cnt[id_src2] > CNT_W'(retire && (wb_dest == id_src2));
    full  = (cnt[issue_dest] == CNT_W'(MAX_PEND)) && !(retire && (wb_dest == issue_dest));
  end

  assign hazard = issue_valid & (pend1 | (two_src & pend2) | (issue_wb_en & full));
  assign accept = issue_valid & issue_wb_en & ~hazard & ~freeze;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (accept) inc_vec[issue_dest] = 1'b1;
    if (retire) dec_vec[wb_dest]    = 1'b1;
  end

  // Scoreboard counters; simultaneous accept and retire on one register cancel out.
  // A retire against a zero count saturates at 0 and flags sb_error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      sb_error <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_W'(1);
        end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
      if (retire && (cnt[wb_dest] == '0)) sb_error <= 1'b1;
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wb_count <= '0;
    else if (retire) wb_count <= wb_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_wb_writeback_unit.sv
module tb_wb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        issue_valid;
  logic        issue_wb_en;
  logic [3:0]  issue_dest;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        two_src;
  logic        mem_valid;
  logic        mem_wb_en;
  logic        mem_r_en;
  logic [3:0]  mem_dest;
  logic [31:0] alu_result;
  logic [31:0] mem_data;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        hazard;
  logic        sb_error;
`ifdef WB_STATS_EN
  logic [31:0] wb_count;
`endif

  wb_writeback_unit #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(16), .MAX_PEND(3)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
    .id_src1(id_src1), .id_src2(id_src2), .two_src(two_src),
    .mem_valid(mem_valid), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_dest(mem_dest),
    .alu_result(alu_result), .mem_data(mem_data),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .hazard(hazard), .sb_error(sb_error)
`ifdef WB_STATS_EN
    , .wb_count(wb_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv, iwe;
    logic [3:0]  idest, s1, s2;
    logic        two;
    logic        mv, mwe, mre;
    logic [3:0]  mdest;
    logic [31:0] alu, mdata;
    logic        e_wb_en;
    logic [3:0]  e_dest;
    logic [31:0] e_value;
    logic        e_haz;
  } vec_t;

  vec_t tbl [16];
  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  int pulses;

  function automatic vec_t v(input logic iv, input logic iwe, input logic [3:0] idest,
                             input logic [3:0] s1, input logic [3:0] s2, input logic two,
                             input logic mv, input logic mwe, input logic mre,
                             input logic [3:0] mdest, input logic [31:0] alu,
                             input logic [31:0] mdata, input logic ewe,
                             input logic [3:0] edest, input logic [31:0] evalue,
                             input logic ehaz);
    vec_t t;
    t.iv = iv; t.iwe = iwe; t.idest = idest; t.s1 = s1; t.s2 = s2; t.two = two;
    t.mv = mv; t.mwe = mwe; t.mre = mre; t.mdest = mdest; t.alu = alu; t.mdata = mdata;
    t.e_wb_en = ewe; t.e_dest = edest; t.e_value = evalue; t.e_haz = ehaz;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    issue_valid = t.iv; issue_wb_en = t.iwe; issue_dest = t.idest;
    id_src1 = t.s1; id_src2 = t.s2; two_src = t.two;
    mem_valid = t.mv; mem_wb_en = t.mwe; mem_r_en = t.mre; mem_dest = t.mdest;
    alu_result = t.alu; mem_data = t.mdata;
  endtask

  task automatic clear_inputs();
    apply(v(0,0,0, 0,0,0, 0,0,0,0, 32'h0,32'h0, 0,0,32'h0,0));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    freeze = 1'b0;
    clear_inputs();

    // Reset state
    @(negedge clk);
    chk("reset wb_en", 32'(wb_en), 32'd0);
    chk("reset wb_dest", 32'(wb_dest), 32'd0);
    chk("reset wb_value", wb_value, 32'd0);
    chk("reset hazard", 32'(hazard), 32'd0);
    chk("reset sb_error", 32'(sb_error), 32'd0);
    next_cycle();
    rst = 1'b0;

    // Each row is one cycle; expectations are the combinational outputs during that cycle.
    tbl[0]  = v(1,1,5, 0,0,0, 0,0,0,0, 32'h0,32'h0,              0,0,32'h0,0);
    tbl[1]  = v(1,1,6, 0,0,0, 1,1,1,5, 32'h11,32'hDEADBEEF,      0,0,32'h0,0);
    tbl[2]  = v(0,0,0, 0,0,0, 1,1,0,6, 32'h11,32'hDEADBEEF,      1,5,32'hDEADBEEF,0);
    tbl[3]  = v(1,0,0, 5,6,1, 0,0,0,0, 32'h0,32'h0,              1,6,32'h11,0);
    tbl[4]  = v(1,1,3, 0,0,0, 0,0,0,0, 32'h0,32'h0,              0,0,32'h0,0);
    tbl[5]  = v(1,0,0, 3,0,0, 1,1,0,3, 32'hA5,32'h0,             0,0,32'h0,1);
    tbl[6]  = v(1,0,0, 3,0,0, 0,0,0,0, 32'h0,32'h0,              1,3,32'hA5,0);
    tbl[7]  = v(1,0,0, 3,3,1, 0,0,0,0, 32'h0,32'h0,              0,0,32'h0,0);
    tbl[8]  = v(1,1,7, 0,0,0, 0,0,0,0, 32'h0,32'h0,              0,0,32'h0,0);
    tbl[9]  = v(1,1,7, 0,0,0, 0,0,0,0, 32'h0,32'h0,              0,0,32'h0,0);
    tbl[10] = v(1,1,7, 0,0,0, 0,0,0,0, 32'h0,32'h0,              0,0,32'h0,0);
    tbl[11] = v(1,1,7, 0,0,0, 1,1,0,7, 32'h77,32'h0,             0,0,32'h0,1);
    tbl[12] = v(1,1,7, 0,0,0, 0,0,0,0, 32'h0,32'h0,              1,7,32'h77,0);
    tbl[13] = v(1,1,7, 0,0,0, 0,0,0,0, 32'h0,32'h0,              0,0,32'h0,1);
    tbl[14] = v(1,0,0, 0,7,0, 0,0,0,0, 32'h0,32'h0,              0,0,32'h0,0);
    tbl[15] = v(1,0,0, 0,7,1, 0,0,0,0, 32'h0,32'h0,              0,0,32'h0,1);

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("row%0d wb_en", i), 32'(wb_en), 32'(tbl[i].e_wb_en));
      chk($sformatf("row%0d wb_dest", i), 32'(wb_dest), 32'(tbl[i].e_dest));
      chk($sformatf("row%0d wb_value", i), wb_value, tbl[i].e_value);
      chk($sformatf("row%0d hazard", i), 32'(hazard), 32'(tbl[i].e_haz));
      chk($sformatf("row%0d sb_error", i), 32'(sb_error), 32'd0);
      if (tbl[i].e_wb_en) exp_count++;
      next_cycle();
    end

    // Freeze: held write to r2 retires exactly once after release
    clear_inputs();
    issue_valid = 1; issue_wb_en = 1; issue_dest = 2;
    next_cycle();
    clear_inputs();
    mem_valid = 1; mem_wb_en = 1; mem_dest = 2; alu_result = 32'h22;
    next_cycle();
    pulses = 0;
    mem_dest = 4; alu_result = 32'h44;
    issue_valid = 1; id_src1 = 2;
    freeze = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wb_en) pulses++;
      chk($sformatf("frz%0d wb_en", c), 32'(wb_en), 32'd0);
      chk($sformatf("frz%0d wb_dest", c), 32'(wb_dest), 32'd2);
      chk($sformatf("frz%0d wb_value", c), wb_value, 32'h22);
      chk($sformatf("frz%0d hazard", c), 32'(hazard), 32'd1);
      next_cycle();
    end
    freeze = 0;
    mem_valid = 0; mem_wb_en = 0; mem_dest = 0; alu_result = 0;
    @(negedge clk);
    if (wb_en) pulses++;
    chk("unfrz wb_en", 32'(wb_en), 32'd1);
    chk("unfrz wb_dest", 32'(wb_dest), 32'd2);
    chk("unfrz hazard", 32'(hazard), 32'd0);
    exp_count++;
    next_cycle();
    @(negedge clk);
    if (wb_en) pulses++;
    chk("post wb_en", 32'(wb_en), 32'd0);
    chk("post wb_dest", 32'(wb_dest), 32'd0);
    chk("post hazard r2", 32'(hazard), 32'd0);
    chk("post sb_error", 32'(sb_error), 32'd0);
    chk("freeze pulse count", 32'(pulses), 32'd1);
    next_cycle();

    // Retire of r9 with nothing pending
    clear_inputs();
    mem_valid = 1; mem_wb_en = 1; mem_dest = 9; alu_result = 32'h99;
    @(negedge clk);
    chk("sb pre sb_error", 32'(sb_error), 32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("sb retire wb_en", 32'(wb_en), 32'd1);
    chk("sb retire wb_dest", 32'(wb_dest), 32'd9);
    exp_count++;
    next_cycle();
    issue_valid = 1; id_src1 = 9;
    @(negedge clk);
    chk("sb set sb_error", 32'(sb_error), 32'd1);
    chk("sb cnt9 zero", 32'(hazard), 32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("sb held sb_error", 32'(sb_error), 32'd1);
`ifdef WB_STATS_EN
    chk("wb_count", wb_count, 32'(exp_count));
`endif
    next_cycle();

    // Reset mid-stream with a write to r8 in flight and r7 full
    issue_valid = 1; issue_wb_en = 1; issue_dest = 8;
    mem_valid = 1; mem_wb_en = 1; mem_dest = 8; alu_result = 32'h88;
    next_cycle();
    clear_inputs();
    issue_valid = 1; id_src1 = 8; id_src2 = 7; two_src = 1;
    #1;
    chk("pre-rst wb_en", 32'(wb_en), 32'd1);
    chk("pre-rst hazard", 32'(hazard), 32'd1);
    rst = 1;
    #1;
    chk("rst wb_en", 32'(wb_en), 32'd0);
    chk("rst wb_dest", 32'(wb_dest), 32'd0);
    chk("rst wb_value", wb_value, 32'd0);
    chk("rst hazard", 32'(hazard), 32'd0);
    chk("rst sb_error", 32'(sb_error), 32'd0);
`ifdef WB_STATS_EN
    chk("rst wb_count", wb_count, 32'd0);
`endif
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("after rst wb_en", 32'(wb_en), 32'd0);
    chk("after rst hazard", 32'(hazard), 32'd0);
    issue_wb_en = 1; issue_dest = 7; two_src = 0;
    #1;
    chk("after rst r7 not full", 32'(hazard), 32'd0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
